mux2_sweep_tester: RTL and testbench
====================================

// Module: mux2_sweep_tester
// PURPOSE
//  Self-checking stimulus stage wrapped around the 2:1 mux (f = s ? w1 : w0).
//  On start, sweeps all 8 {s,w0,w1} combinations, holds each for HOLD_CYCLES,
//  samples the mux output f and compares it against the expected value.
//  Reports the error count, a per-vector fail map and pass/done flags.
//  Drives the mux inputs directly and consumes f, so it replaces a timed bench.
// PARAMETERS
//  HOLD_CYCLES  20  cycles each vector is held (min 2); f is sampled on the last.
// PORTS
//  clk        in   1  single clock, rising edge.
//  rst        in   1  asynchronous, active-high reset.
//  start      in   1  begin a sweep; sampled only in IDLE or DONE.
//  s          out  1  mux select, registered.
//  w0         out  1  mux data 0, registered.
//  w1         out  1  mux data 1, registered.
//  f          in   1  mux output under test.
//  busy       out  1  high while the sweep is running.
//  done       out  1  high from sweep end until the next start.
//  pass       out  1  done && err_count==0.
//  err_count  out  4  number of mismatching vectors, 0..8.
//  fail_vec   out  8  bit i set if vector i mismatched.
// BEHAVIOUR
//  Reset: state=IDLE; s,w0,w1,busy,done,pass=0; err_count=0; fail_vec=0;
//   idx=0; hold_cnt=0. Reset mid-sweep aborts at once and no result is kept.
//  Vector encoding: idx[2:0] -> {s,w0,w1} = {idx[2],idx[1],idx[0]}.
//   expected = idx[2] ? idx[0] : idx[1].
//  States:
//   IDLE : outputs at reset values. start=1 at edge E0 -> DRIVE, idx=0,
//          hold_cnt=0, busy=1, err_count=0, fail_vec=0, {s,w0,w1}=3'b000.
//   DRIVE: hold_cnt++ every edge. At the edge where hold_cnt==HOLD_CYCLES-1:
//          compare f with expected; on mismatch err_count++, fail_vec[idx]=1;
//          hold_cnt=0. If idx<7: idx++ and drive the new vector on that edge.
//          If idx==7: -> DONE.
//   DONE : busy=0, done=1, pass=(final err_count==0); s,w0,w1 return to 0.
//          err_count and fail_vec are held. start=1 -> same entry as from IDLE
//          (done and pass clear on that edge).
//  Timing: vector i is driven for exactly HOLD_CYCLES cycles, starting at
//   E0+i*HOLD_CYCLES. done rises at edge E0+8*HOLD_CYCLES.
//  start while busy is ignored; a held-high start from DONE restarts the sweep.
//  f is sampled only on the compare edge, so a glitch between compare edges
//   does not count as a mismatch.
//  err_count saturates naturally at 8 (4 bits, never wraps). idx never wraps
//   past 7.
// STRUCTURE
//  Shared include mux2_tester_defs.vh: state localparams (IDLE, DRIVE, DONE),
//   NUM_VECTORS=8, and the expected-value function for the mux.
//  One sub-module, hold_timer: HOLD_CYCLES down-counter with a load input and
//   a last_cycle output. The FSM, vector index and scoreboard stay in the top.
// TESTING
//  1. Correct mux, HOLD_CYCLES=20, start pulse -> done at E0+160, err_count=0,
//     fail_vec=8'h00, pass=1, and {s,w0,w1} steps 000..111 every 20 cycles.
//  2. f tied 0 -> err_count=4, fail_vec=8'b1010_1100, pass=0.
//  3. Swapped mux (f = s ? w0 : w1) -> err_count=4, fail_vec=8'b0110_0110.
//  4. Inverted mux output -> err_count=8, fail_vec=8'hFF, pass=0.
//  5. start pulsed during vector 3 -> ignored; done still at E0+160.
//     start pulsed in DONE -> new sweep, done=0 and pass=0 on that edge.
//  6. rst asserted mid-vector 3 -> all outputs 0 immediately (asynchronous);
//     release, start -> full sweep completes with the correct result.

Source files
------------

// File: rtl/mux2_sweep_tester_pkg.sv
// Shared definitions for the 2:1 mux sweep tester: FSM states, vector count
// and the reference function for the mux under test.
package mux2_sweep_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         NUM_VECTORS = 8;
  localparam logic [2:0] LAST_IDX    = 3'(NUM_VECTORS - 1);

  // Vector bits are {s, w0, w1}; the mux returns w1 when s is set.
  function automatic logic mux_expected(input logic [2:0] vec);
    return vec[2] ? vec[0] : vec[1];
  endfunction

endpackage

// File: rtl/mux2_sweep_tester_hold_timer.sv
// Down-counter that paces each vector: load starts a HOLD_CYCLES window and
// last_cycle flags the final cycle of that window while enabled.
module hold_timer #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last_cycle
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(HOLD_CYCLES - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last_cycle = en && (cnt == '0);

endmodule

// File: rtl/mux2_sweep_tester.sv
// Drives all eight {s,w0,w1} vectors into a 2:1 mux, samples f on the last
// cycle of each hold window and accumulates an error count and fail map.
module mux2_sweep_tester
  import mux2_sweep_tester_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       s,
  output logic       w0,
  output logic       w1,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  state_t     state;
  logic [2:0] idx;
  logic       last_cycle;
  logic       timer_load;
  logic       timer_en;
  logic       mismatch;
  logic [3:0] err_next;

  // The timer restarts on sweep entry and on every vector advance.
  assign timer_en   = (state == DRIVE);
  assign timer_load = (state != DRIVE) ? start : (last_cycle && idx != LAST_IDX);
  assign mismatch   = (f != mux_expected(idx));
  assign err_next   = err_count + {3'b000, mismatch};

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .en        (timer_en),
    .last_cycle(last_cycle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      s          <= 1'b0;
      w0         <= 1'b0;
      w1         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= DRIVE;
            idx         <= '0;
            {s, w0, w1} <= 3'b000;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_vec    <= '0;
          end
        end
        DRIVE: begin
          if (last_cycle) begin
            err_count <= err_next;
            if (mismatch) begin
              fail_vec[idx] <= 1'b1;
            end
            if (idx == LAST_IDX) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              pass        <= (err_next == 4'd0);
              {s, w0, w1} <= 3'b000;
            end else begin
              idx         <= idx + 3'd1;
              {s, w0, w1} <= idx + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_sweep_tester.sv
// Bench for mux2_sweep_tester: plugs in good and faulty muxes, randomizes
// start timing, stray start pulses and reset points, and checks each sweep.
module tb_mux2_sweep_tester;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       s, w0, w1, f;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  int mode;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Mux under test: 0 correct, 1 stuck at 0, 2 data inputs swapped, 3 inverted.
  assign f = (mode == 0) ? (s ? w1 : w0) :
             (mode == 1) ? 1'b0 :
             (mode == 2) ? (s ? w0 : w1) :
                           ~(s ? w1 : w0);

  mux2_sweep_tester #(
    .HOLD_CYCLES(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s        (s),
    .w0       (w0),
    .w1       (w1),
    .f        (f),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fail map from first principles: vector v is {s,w0,w1} = bits of v.
  function automatic logic [7:0] model_fail(input int m);
    logic [7:0] r;
    int sel, a, b, ideal, got;
    r = '0;
    for (int v = 0; v < 8; v++) begin
      sel   = (v >> 2) & 1;
      a     = (v >> 1) & 1;
      b     = v & 1;
      ideal = sel ? b : a;
      case (m)
        0:       got = ideal;
        1:       got = 0;
        2:       got = sel ? a : b;
        default: got = 1 - ideal;
      endcase
      if (got != ideal) r[v] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_vec"}, {s, w0, w1}, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_failvec"}, fail_vec, 0);
  endtask

  // One full sweep starting at the next edge; optionally pokes start during vector 3.
  task automatic sweep(input int m, input bit poke);
    int         pc;
    logic [7:0] exp_fail;
    pc       = 3 * H + int'($urandom_range(0, H - 1));
    exp_fail = model_fail(m);
    mode     = m;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("entry_done", done, 0);
    chk("entry_pass", pass, 0);
    chk("entry_err", err_count, 0);
    chk("entry_failvec", fail_vec, 0);
    for (int c = 0; c < 8 * H; c++) begin
      chk("vector", {s, w0, w1}, c / H);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      start = poke && (c == pc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_vec", {s, w0, w1}, 0);
    chk("end_err", err_count, $countones(exp_fail));
    chk("end_failvec", fail_vec, exp_fail);
    chk("end_pass", pass, (exp_fail == 8'h00));
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    n = int'($urandom_range(1, 5));
    repeat (n) @(posedge clk);
    #1;
    chk_all_zero("idle");

    sweep(0, 1'b0);
    n = int'($urandom_range(1, 6));
    repeat (n) @(posedge clk);
    #1;
    chk("done_hold", done, 1);
    chk("pass_hold", pass, 1);

    sweep(1, 1'b1);
    sweep(2, 1'($urandom_range(0, 1)));
    sweep(3, 1'b0);

    // Abort mid-vector 3 with a faulty mux so there is a result to lose.
    mode  = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3 * H + int'($urandom_range(0, H - 2));
    repeat (n) @(posedge clk);
    #1;
    chk("pre_abort_vec", {s, w0, w1}, 3);
    chk("pre_abort_err", err_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("post_rst");
    sweep(0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
